// File: rtl/ei_tdp_ram.sv
// True dual-port RAM with one clock. Each port can read and write every cycle.
// Read data is registered. A port that writes and reads in the same cycle
// returns its own new data. A port that reads an address the other port is
// writing returns the old contents.
// When both ports write the same address, port A's data is stored.
// A collision flag marks cycles that follow a same-address access in which
// at least one port was writing.
module ei_tdp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic                  re_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] out_a_q;
  logic [DATA_WIDTH-1:0] out_b_q;
  logic                  valid_a_q;
  logic                  valid_b_q;
  logic                  collision_q;
  logic                  collision_d;
  logic                  same_addr;
  logic                  wr_b_ok;

  assign same_addr = (addr_a == addr_b);
  // Port B loses a same-address write race against port A.
  assign wr_b_ok   = we_b && !(we_a && same_addr);

  // Flag a same-address access when at least one of the two ports is writing.
  always_comb begin
    collision_d = (we_a || re_a) && (we_b || re_b) && same_addr && (we_a || we_b);
  end

  // Memory writes. Writes are blocked while reset is high. The array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_b_ok) mem_q[addr_b] <= data_b;
      if (we_a)    mem_q[addr_a] <= data_a;
    end
  end

  // Registered read ports and collision flag. Reset clears them at once, without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      valid_a_q   <= 1'b0;
      valid_b_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      valid_a_q   <= re_a;
      valid_b_q   <= re_b;
      collision_q <= collision_d;
      // A port that also writes returns its own data. Otherwise it returns the old contents.
      if (re_a) out_a_q <= we_a ? data_a : mem_q[addr_a];
      if (re_b) out_b_q <= we_b ? data_b : mem_q[addr_b];
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign valid_a   = valid_a_q;
  assign valid_b   = valid_b_q;
  assign collision = collision_q;

  // An unknown enable is a simulation error.
  // The write logic treats an unknown enable as "no write", so memory is left untouched.
  a_enables_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({we_a, we_b, re_a, re_b}));

endmodule
